// File: rtl/lsb_queue.sv
// In-order load/store buffer between issue and the memory controller.
// Wakes operands from RS/LSB broadcasts and executes strictly from head.
module lsb_queue #(
  parameter int LSB_SIZE_BIT = 4,
  parameter int ROB_SIZE_BIT = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic [ROB_SIZE_BIT-1:0] rob_head_id,
  input  logic                    lsb_input,
  input  logic [3:0]              lsb_op,
  input  logic [31:0]             lsb_rs1_val,
  input  logic [31:0]             lsb_rs2_val,
  input  logic                    lsb_rs1_rdy,
  input  logic                    lsb_rs2_rdy,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rs1_dep,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rs2_dep,
  input  logic [31:0]             lsb_imm,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
  input  logic                    rs_fi,
  input  logic [31:0]             rs_value,
  input  logic [ROB_SIZE_BIT-1:0] rs_rob_id,
  output logic                    lsb_full,
  output logic                    lsb_fi,
  output logic [31:0]             lsb_value,
  output logic [ROB_SIZE_BIT-1:0] lsb_res_rob_id,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [31:0]             mem_addr,
  output logic [1:0]              mem_len,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_done,
  input  logic [31:0]             mem_rdata
);

  localparam int SIZE = 1 << LSB_SIZE_BIT;
  localparam int CW   = LSB_SIZE_BIT + 1;

  typedef logic [ROB_SIZE_BIT-1:0] rid_t;
  typedef logic [LSB_SIZE_BIT-1:0] ptr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  logic [SIZE-1:0] valid_q;
  logic [SIZE-1:0] r1_q;
  logic [SIZE-1:0] r2_q;
  logic [3:0]      op_q  [SIZE];
  logic [31:0]     v1_q  [SIZE];
  logic [31:0]     v2_q  [SIZE];
  logic [31:0]     imm_q [SIZE];
  rid_t            d1_q  [SIZE];
  rid_t            d2_q  [SIZE];
  rid_t            id_q  [SIZE];

  ptr_t            head_q;
  ptr_t            tail_q;
  logic [CW-1:0]   count_q;
  state_t          state_q;
  logic            head_match_q;

  logic            h_store;
  logic            h_ready;
  logic            head_match;
  logic            do_issue;
  logic            do_pop;
  logic            do_enq;
  logic [31:0]     ld_value;
  logic [SIZE-1:0] wake1;
  logic [SIZE-1:0] wake2;
  logic            in1_rdy;
  logic            in2_rdy;
  logic [31:0]     in1_val;
  logic [31:0]     in2_val;

  function automatic logic bc_hit(input rid_t dep);
    return (rs_fi && dep == rs_rob_id) ||
           (lsb_fi && dep == lsb_res_rob_id);
  endfunction

  function automatic logic [31:0] bc_val(input rid_t dep);
    return (rs_fi && dep == rs_rob_id) ? rs_value : lsb_value;
  endfunction

  assign lsb_full   = count_q >= CW'(SIZE - 1);
  assign h_store    = op_q[head_q][3];
  assign h_ready    = valid_q[head_q] && r1_q[head_q] &&
                      (!h_store || r2_q[head_q]);
  assign head_match = rob_head_id == id_q[head_q];

  // Stores need the commit point confirmed on two consecutive cycles.
  assign do_issue = rdy_in && !rob_clear && state_q == S_IDLE &&
                    h_ready &&
                    (!h_store || (head_match && head_match_q));
  assign do_pop   = rdy_in && !rob_clear && state_q == S_WAIT && mem_done;
  assign do_enq   = rdy_in && !rob_clear && lsb_input;

  assign in1_rdy = lsb_rs1_rdy || bc_hit(lsb_rs1_dep);
  assign in2_rdy = lsb_rs2_rdy || bc_hit(lsb_rs2_dep);
  assign in1_val = lsb_rs1_rdy ? lsb_rs1_val : bc_val(lsb_rs1_dep);
  assign in2_val = lsb_rs2_rdy ? lsb_rs2_val : bc_val(lsb_rs2_dep);

  // Find entries whose pending operand matches a live broadcast.
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < SIZE; i++) begin
      wake1[i] = valid_q[i] && !r1_q[i] && bc_hit(d1_q[i]);
      wake2[i] = valid_q[i] && !r2_q[i] && bc_hit(d2_q[i]);
    end
  end

  // Extend raw read data according to the head load's width and sign.
  always_comb begin
    ld_value = mem_rdata;
    case (op_q[head_q][2:0])
      3'b000:  ld_value = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  ld_value = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  ld_value = {24'd0, mem_rdata[7:0]};
      3'b101:  ld_value = {16'd0, mem_rdata[15:0]};
      default: ld_value = mem_rdata;
    endcase
  end

  // Entry valid and operand-ready flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
    end else if (rdy_in) begin
      r1_q <= r1_q | wake1;
      r2_q <= r2_q | wake2;
      if (do_pop) valid_q[head_q] <= 1'b0;
      if (do_enq) begin
        valid_q[tail_q] <= 1'b1;
        r1_q[tail_q]    <= in1_rdy;
        r2_q[tail_q]    <= in2_rdy;
      end
      if (rob_clear) valid_q <= '0;
    end
  end

  // Entry payload; only meaningful while the valid flag is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < SIZE; i++) begin
        if (wake1[i]) v1_q[i] <= bc_val(d1_q[i]);
        if (wake2[i]) v2_q[i] <= bc_val(d2_q[i]);
      end
      if (do_enq) begin
        op_q[tail_q]  <= lsb_op;
        v1_q[tail_q]  <= in1_val;
        v2_q[tail_q]  <= in2_val;
        imm_q[tail_q] <= lsb_imm;
        d1_q[tail_q]  <= lsb_rs1_dep;
        d2_q[tail_q]  <= lsb_rs2_dep;
        id_q[tail_q]  <= lsb_rob_id;
      end
    end
  end

  // Pointers, issue FSM and registered memory/ROB outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      state_q        <= S_IDLE;
      head_match_q   <= 1'b0;
      lsb_fi         <= 1'b0;
      lsb_value      <= '0;
      lsb_res_rob_id <= '0;
      mem_req        <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= '0;
      mem_len        <= '0;
      mem_wdata      <= '0;
    end else if (rdy_in) begin
      lsb_fi       <= 1'b0;
      head_match_q <= valid_q[head_q] && head_match && !do_pop;
      if (do_enq) tail_q <= tail_q + 1'b1;
      if (do_pop) head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(do_enq) - CW'(do_pop);
      unique case (state_q)
        S_IDLE: begin
          if (do_issue) begin
            state_q   <= S_WAIT;
            mem_req   <= 1'b1;
            mem_wr    <= h_store;
            mem_addr  <= v1_q[head_q] + imm_q[head_q];
            mem_len   <= op_q[head_q][1:0];
            mem_wdata <= v2_q[head_q];
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            state_q <= S_IDLE;
            if (!rob_clear) begin
              lsb_fi         <= 1'b1;
              lsb_res_rob_id <= id_q[head_q];
              lsb_value      <= h_store ? 32'd0 : ld_value;
            end
          end else if (rob_clear) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (rob_clear) begin
        head_q       <= '0;
        tail_q       <= '0;
        count_q      <= '0;
        head_match_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lsb_queue.md
Name: lsb_queue

Overview:
- In-order load/store buffer between the decoder (issue side) and the unified memory controller.
- Holds up to LSB_SIZE memory ops and wakes up their operands from RS/LSB broadcasts.
- Executes entries strictly from its head and reports finished ops to the ROB via lsb_fi/lsb_value/lsb_rob_id.
- Stores are only written to memory once they are the ROB's commit head.

Parameters:
LSB_SIZE_BIT, 4, log2 of entry count (16 entries)
ROB_SIZE_BIT, 5, width of ROB ids

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global stall when low; all state holds
rob_clear  in  1  flush on mispredict
rob_head_id  in  ROB_SIZE_BIT  ROB id at commit point this cycle
lsb_input  in  1  enqueue strobe from decoder
lsb_op  in  4  {is_store, funct3}; funct3 000 B, 001 H, 010 W, 100 BU, 101 HU
lsb_rs1_val / lsb_rs2_val  in  32 each  operand values
lsb_rs1_rdy / lsb_rs2_rdy  in  1 each  operand valid
lsb_rs1_dep / lsb_rs2_dep  in  ROB_SIZE_BIT each  producer ROB id when not ready
lsb_imm  in  32  sign-extended offset
lsb_rob_id  in  ROB_SIZE_BIT  ROB id of the op
rs_fi, rs_value[32], rs_rob_id[ROB_SIZE_BIT]  in  ALU result broadcast
lsb_full  out  1  decoder must not enqueue
lsb_fi  out  1  result pulse to ROB/RS
lsb_value  out  32  load data (0 for stores)
lsb_res_rob_id  out  ROB_SIZE_BIT  ROB id of finished op
mem_req  out  1  memory request
mem_wr  out  1  1 = store
mem_addr  out  32  byte address
mem_len  out  2  0 byte, 1 half, 2 word
mem_wdata  out  32  store data, LSB-aligned
mem_done  in  1  one-cycle completion pulse
mem_rdata  in  32  raw read data, LSB-aligned

Behaviour:
- Reset: all outputs 0; head = tail = count = 0; all entries invalid; FSM IDLE; head_match_q = 0.
- lsb_full = (count >= LSB_SIZE-1). The one-slot margin covers the decoder's registered-issue latency.
- Enqueue when lsb_input: write entry at tail, tail++ (wraps mod LSB_SIZE).
  - Same-cycle wakeup: if an incoming operand is not ready and its dep equals rs_rob_id with rs_fi high, or lsb_res_rob_id with lsb_fi high, capture the broadcast value and mark it ready.
- Wakeup: every cycle, each valid entry with a not-ready operand whose dep matches an active broadcast captures the value and sets ready.
- Head entry H is issuable when H is valid and both rs1 and rs2 are ready. rs2 is only required for stores; loads treat rs2 as always ready.
- Load issue: in IDLE, a ready load issues immediately.
- Store issue: requires all of the following:
  - rob_head_id == H.rob_id
  - head_match_q == 1, where head_match_q is the registered value of that comparison from the previous cycle
  - rob_clear == 0
  - The two-cycle confirmation blocks the transient head+1 id that appears during a mispredicted branch's pop cycle.
- FSM:
  - IDLE → WAIT on issue. Registered on that edge: mem_req=1, mem_wr, mem_addr = rs1+imm (32-bit wrap, no alignment check), mem_len from funct3[1:0], mem_wdata = rs2.
  - WAIT: hold all mem_* stable until mem_done.
  - On mem_done: mem_req=0; pop head (head++, count--); drive lsb_fi=1 for one cycle with lsb_res_rob_id = H.rob_id. lsb_value is mem_rdata sign-extended (B/H) or zero-extended (BU/HU), word unchanged; stores report 0. Return to IDLE.
  - Same edge as the done-pop: an enqueue may coexist (count unchanged).
- Latency: a ready load at head in IDLE gives mem_req at +1 cycle and lsb_fi on the cycle after mem_done.
- rob_clear in IDLE: invalidate all entries; head = tail = count = 0; lsb_fi cleared.
- rob_clear in WAIT: entries flushed likewise, but the request is held until mem_done (the controller cannot abort).
  - FSM goes to DRAIN; on mem_done return to IDLE with no lsb_fi.
  - A store is never in flight at clear, guaranteed by the issue rule.
  - No new issue while in DRAIN. Enqueues in DRAIN are accepted.
- rob_clear has priority over same-cycle lsb_input, which is dropped.
- rdy_in low: nothing changes, including wakeups. mem_done is only sampled when rdy_in is high.
- Asynchronous reset mid-request: immediate return to the reset state; no completion reported.

Test Plan:
- Enqueue LW rs1=0x1000 (ready), imm=4, rob_id=3 → mem_req=1, mem_wr=0, mem_addr=0x1004, len=2 next cycle; mem_done with rdata=0xDEADBEEF → lsb_fi=1, value=0xDEADBEEF, id=3 for exactly one cycle.
- LB and LBU with rdata=0x00000080 → values 0xFFFFFF80 and 0x00000080; LH with rdata=0x0000_8001 → 0xFFFF8001.
- SW rob_id=5, rs2=0x12345678, rob_head_id held at 4 → no mem_req; head becomes 5 → mem_req asserted after two matching cycles with wdata=0x12345678, wr=1; mem_done → lsb_fi, value 0.
- Load rs1 not ready (dep=7), then rs_fi with id 7, value 0x2000 → entry wakes and issues with addr=0x2000+imm. Repeat with the broadcast arriving in the same cycle as enqueue → captured.
- Fill until lsb_full=1 at 15 entries; wrap tail past index 15 and drain → FIFO order preserved.
- rob_clear during WAIT of a load → all entries gone, mem_req held until mem_done, no lsb_fi; rob_head_id transiently equals a younger store's id for one cycle before clear → store never issues.
